// File: rtl/button_event_capture.sv
// Synchronises and debounces eight push-button pins and latches sticky press (and optionally
// release) events. Build with `BTN_RELEASE_EVENT_EN defined to add sticky release events.
module button_event_capture #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] BUTTON,
    input  logic       CLR_VALID,
    input  logic [7:0] CLR_MASK,
    input  logic       IRQ_EN,
    output logic [7:0] BTN_STATE,
    output logic [7:0] BTN_EVENT,
    output logic [7:0] BTN_REL_EVENT,
    output logic       IRQ
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [CW-1:0] cnt     [8];
    logic [CW-1:0] cnt_nxt [8];
    logic [7:0]    state_nxt;
    logic [7:0]    press_edge;
    logic [7:0]    clr_bits;
    logic [7:0]    evt_nxt;
    logic          pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
        end else begin
            s1 <= BUTTON;
            s2 <= s1;
        end
    end

    // A level change is accepted only after the counter has seen it for the full window;
    // any return to the current level restarts the count from zero.
    always_comb begin
        state_nxt = BTN_STATE;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != BTN_STATE[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    state_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
            BTN_STATE <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            BTN_STATE <= state_nxt;
        end
    end

    // Set has priority over a coincident clear so no press is ever lost.
    always_comb begin
        press_edge = state_nxt & ~BTN_STATE;
        clr_bits   = CLR_VALID ? CLR_MASK : 8'h00;
        evt_nxt    = (BTN_EVENT & ~clr_bits) | press_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BTN_EVENT <= 8'h00;
        end else begin
            BTN_EVENT <= evt_nxt;
        end
    end

`ifdef BTN_RELEASE_EVENT_EN
    logic [7:0] rel_edge;
    logic [7:0] rel_nxt;

    always_comb begin
        rel_edge = BTN_STATE & ~state_nxt;
        rel_nxt  = (BTN_REL_EVENT & ~clr_bits) | rel_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BTN_REL_EVENT <= 8'h00;
        end else begin
            BTN_REL_EVENT <= rel_nxt;
        end
    end
`else
    assign BTN_REL_EVENT = 8'h00;
`endif

    assign pending = (|BTN_EVENT) | (|BTN_REL_EVENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= IRQ_EN & pending;
        end
    end

endmodule

// File: tb/tb_button_event_capture.sv
// Directed bench for button_event_capture with a 4-cycle debounce window.
module tb_button_event_capture;

    localparam int DC = 4;

`ifdef BTN_RELEASE_EVENT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] BUTTON;
    logic       CLR_VALID;
    logic [7:0] CLR_MASK;
    logic       IRQ_EN;
    logic [7:0] BTN_STATE;
    logic [7:0] BTN_EVENT;
    logic [7:0] BTN_REL_EVENT;
    logic       IRQ;

    int errors = 0;
    int checks = 0;

    button_event_capture #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .BUTTON        (BUTTON),
        .CLR_VALID     (CLR_VALID),
        .CLR_MASK      (CLR_MASK),
        .IRQ_EN        (IRQ_EN),
        .BTN_STATE     (BTN_STATE),
        .BTN_EVENT     (BTN_EVENT),
        .BTN_REL_EVENT (BTN_REL_EVENT),
        .IRQ           (IRQ)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cleanup();
        BUTTON = 8'h00;
        edges(8);
        CLR_VALID = 1'b1;
        CLR_MASK  = 8'hFF;
        edges(1);
        CLR_VALID = 1'b0;
        CLR_MASK  = 8'h00;
        edges(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        BUTTON = 8'h00;
        CLR_VALID = 1'b0;
        CLR_MASK = 8'h00;
        IRQ_EN = 1'b1;
        edges(2);
        checks++; if (BTN_STATE !== 8'h00) begin errors++; $display("FAIL reset_state got=%h exp=00", BTN_STATE); end
        checks++; if (BTN_EVENT !== 8'h00) begin errors++; $display("FAIL reset_event got=%h exp=00", BTN_EVENT); end
        checks++; if (BTN_REL_EVENT !== 8'h00) begin errors++; $display("FAIL reset_rel got=%h exp=00", BTN_REL_EVENT); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
        rst_n = 1'b1;
        edges(2);
    endtask

    task automatic test_clean_press();
        BUTTON = 8'h01;
        edges(5);   // through edge 4
        checks++; if (BTN_STATE !== 8'h00) begin errors++; $display("FAIL press_early_state got=%h exp=00", BTN_STATE); end
        edges(1);   // edge 5
        checks++; if (BTN_STATE !== 8'h01) begin errors++; $display("FAIL press_state got=%h exp=01", BTN_STATE); end
        checks++; if (BTN_EVENT !== 8'h01) begin errors++; $display("FAIL press_event got=%h exp=01", BTN_EVENT); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL press_irq_early got=%b exp=0", IRQ); end
        edges(1);   // edge 6
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL press_irq got=%b exp=1", IRQ); end
    endtask

    task automatic test_partial_clear();
        BUTTON = 8'h81;
        edges(7);
        checks++; if (BTN_EVENT !== 8'h81) begin errors++; $display("FAIL pc_pending got=%h exp=81", BTN_EVENT); end
        CLR_VALID = 1'b1;
        CLR_MASK  = 8'h01;
        edges(1);
        CLR_VALID = 1'b0;
        CLR_MASK  = 8'h00;
        checks++; if (BTN_EVENT !== 8'h80) begin errors++; $display("FAIL pc_first got=%h exp=80", BTN_EVENT); end
        edges(1);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL pc_irq_held got=%b exp=1", IRQ); end
        CLR_VALID = 1'b1;
        CLR_MASK  = 8'h80;
        edges(1);
        CLR_VALID = 1'b0;
        CLR_MASK  = 8'h00;
        checks++; if (BTN_EVENT !== 8'h00) begin errors++; $display("FAIL pc_second got=%h exp=00", BTN_EVENT); end
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL pc_irq_same_edge got=%b exp=1", IRQ); end
        edges(1);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL pc_irq_fall got=%b exp=0", IRQ); end
        BUTTON = 8'h00;
        edges(8);
        checks++; if (BTN_STATE !== 8'h00) begin errors++; $display("FAIL pc_released got=%h exp=00", BTN_STATE); end
        checks++; if (BTN_EVENT !== 8'h00) begin errors++; $display("FAIL pc_no_press_on_release got=%h exp=00", BTN_EVENT); end
        checks++; if (BTN_REL_EVENT !== (REL_EN ? 8'h81 : 8'h00)) begin errors++; $display("FAIL pc_rel got=%h exp=%h", BTN_REL_EVENT, REL_EN ? 8'h81 : 8'h00); end
        checks++; if (IRQ !== REL_EN) begin errors++; $display("FAIL pc_rel_irq got=%b exp=%b", IRQ, REL_EN); end
        cleanup();
    endtask

    task automatic test_glitch();
        BUTTON = 8'h08;
        edges(3);
        BUTTON = 8'h00;
        for (int k = 0; k < 10; k++) begin
            edges(1);
            checks++; if (BTN_STATE !== 8'h00 || BTN_EVENT !== 8'h00 || IRQ !== 1'b0) begin
                errors++;
                $display("FAIL glitch_%0d got state=%h event=%h irq=%b exp 00/00/0", k, BTN_STATE, BTN_EVENT, IRQ);
            end
        end
        // A follow-up press must still need the full window, proving the count was discarded.
        BUTTON = 8'h08;
        edges(5);
        checks++; if (BTN_STATE !== 8'h00) begin errors++; $display("FAIL glitch_after_early got=%h exp=00", BTN_STATE); end
        edges(1);
        checks++; if (BTN_EVENT !== 8'h08) begin errors++; $display("FAIL glitch_after_press got=%h exp=08", BTN_EVENT); end
        cleanup();
    endtask

    task automatic test_collision();
        BUTTON = 8'h04;
        edges(5);   // through edge 4; edge 5 is the rising edge of BTN_STATE[2]
        CLR_VALID = 1'b1;
        CLR_MASK  = 8'h04;
        edges(1);
        CLR_VALID = 1'b0;
        CLR_MASK  = 8'h00;
        checks++; if (BTN_STATE !== 8'h04) begin errors++; $display("FAIL coll_state got=%h exp=04", BTN_STATE); end
        checks++; if (BTN_EVENT !== 8'h04) begin errors++; $display("FAIL coll_event got=%h exp=04", BTN_EVENT); end
        edges(2);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL coll_irq got=%b exp=1", IRQ); end
        IRQ_EN = 1'b0;
        edges(1);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_en_off got=%b exp=0", IRQ); end
        IRQ_EN = 1'b1;
        edges(1);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_en_on got=%b exp=1", IRQ); end
    endtask

    // Runs with BUTTON[2] still held and its event pending from test_collision.
    task automatic test_reset_mid();
        BUTTON = 8'hFF;
        edges(4);   // edges 0..3: two counted cycles on the new bits
        rst_n = 1'b0;
        #1;
        checks++; if (BTN_STATE !== 8'h00) begin errors++; $display("FAIL rm_state got=%h exp=00", BTN_STATE); end
        checks++; if (BTN_EVENT !== 8'h00) begin errors++; $display("FAIL rm_event got=%h exp=00", BTN_EVENT); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL rm_irq got=%b exp=0", IRQ); end
        edges(3);
        rst_n = 1'b1;
        edges(5);   // edges 0..4 after release
        checks++; if (BTN_STATE !== 8'h00) begin errors++; $display("FAIL rm_early got=%h exp=00", BTN_STATE); end
        edges(1);
        checks++; if (BTN_STATE !== 8'hFF) begin errors++; $display("FAIL rm_after_state got=%h exp=ff", BTN_STATE); end
        checks++; if (BTN_EVENT !== 8'hFF) begin errors++; $display("FAIL rm_after_event got=%h exp=ff", BTN_EVENT); end
        cleanup();
    endtask

    task automatic test_release();
        BUTTON = 8'h01;
        edges(8);
        CLR_VALID = 1'b1;
        CLR_MASK  = 8'hFF;
        edges(1);
        CLR_VALID = 1'b0;
        CLR_MASK  = 8'h00;
        edges(2);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL rel_pre_irq got=%b exp=0", IRQ); end
        BUTTON = 8'h00;
        edges(5);
        checks++; if (BTN_REL_EVENT !== 8'h00 || BTN_STATE !== 8'h01) begin errors++; $display("FAIL rel_early got rel=%h state=%h exp 00/01", BTN_REL_EVENT, BTN_STATE); end
        edges(1);
        checks++; if (BTN_STATE !== 8'h00) begin errors++; $display("FAIL rel_state got=%h exp=00", BTN_STATE); end
        checks++; if (BTN_REL_EVENT !== (REL_EN ? 8'h01 : 8'h00)) begin errors++; $display("FAIL rel_event got=%h exp=%h", BTN_REL_EVENT, REL_EN ? 8'h01 : 8'h00); end
        checks++; if (BTN_EVENT !== 8'h00) begin errors++; $display("FAIL rel_press_evt got=%h exp=00", BTN_EVENT); end
        edges(1);
        checks++; if (IRQ !== REL_EN) begin errors++; $display("FAIL rel_irq got=%b exp=%b", IRQ, REL_EN); end
        CLR_VALID = 1'b1;
        CLR_MASK  = 8'h01;
        edges(1);
        CLR_VALID = 1'b0;
        CLR_MASK  = 8'h00;
        checks++; if (BTN_REL_EVENT !== 8'h00) begin errors++; $display("FAIL rel_clear got=%h exp=00", BTN_REL_EVENT); end
        edges(1);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL rel_irq_fall got=%b exp=0", IRQ); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_partial_clear();
        test_glitch();
        test_collision();
        test_reset_mid();
        test_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
